ps2_key_decoder: RTL
====================

// Module: ps2_key_decoder
// PURPOSE
//  Upstream input stage for the game core. Receives PS/2 set-2 scan-code frames and decodes make/break
//  sequences, including E0 and F0 prefixes. Drives the 5-bit KEY_PRESSED code consumed by the directions
//  block: codes 0-15 are {player[1:0], dir[1:0]} with dir 00=up, 01=down, 10=left, 11=right; code 16 is
//  game reset; IDLE_CODE means no key is held.
// PARAMETERS
//  TIMEOUT_CYCLES  50000  CLOCK_50 cycles without a PS2_CLK falling edge mid-frame before the frame is aborted (1 ms)
//  FILTER_LEN      8      consecutive equal samples required to accept a PS2_CLK level (glitch filter only)
//  IDLE_CODE       5'd31  KEY_PRESSED value when no mapped key is held
// PORTS
//  CLOCK_50     in   1  system clock; only clock domain
//  reset        in   1  synchronous, active-high reset
//  PS2_CLK      in   1  PS/2 clock from the keyboard, asynchronous
//  PS2_DAT      in   1  PS/2 data from the keyboard, asynchronous
//  KEY_PRESSED  out  5  current key code, held while the key is down
//  key_valid    out  1  1-cycle pulse when KEY_PRESSED takes a new non-idle code
//  frame_err    out  1  1-cycle pulse on parity, start, stop or timeout error
// BEHAVIOUR
//  Reset values: KEY_PRESSED=IDLE_CODE, key_valid=0, frame_err=0, FSM=IDLE, ext/brk flags=0, shift reg=0, timeout=0.
//  Input sync: PS2_CLK and PS2_DAT each pass through a 2-FF synchronizer. A falling edge is detected on the synced clock.
//  Frame: 11 bits = start(0), 8 data bits LSB first, odd parity, stop(1). Each bit is sampled on a falling edge.
//  FSM: IDLE -(edge & dat==0)-> DATA.
//    DATA -(8th bit)-> PARITY -(edge)-> STOP -(edge)-> DONE -> IDLE (DONE lasts 1 cycle).
//    In IDLE, an edge with dat==1 is a bad start bit: frame_err pulses and the FSM stays in IDLE.
//  Timeout: the counter clears on every edge and counts in DATA, PARITY and STOP.
//    When it reaches TIMEOUT_CYCLES: go to IDLE, pulse frame_err, clear ext/brk.
//  DONE with bad parity or stop==0: discard the byte, pulse frame_err, clear ext/brk.
//  Byte handling in DONE:
//    E0 sets ext. F0 sets brk. Any other byte is a key byte.
//    After a key byte, ext and brk are always cleared.
//  Key map (ext:byte -> code):
//    P1: E0:75 -> 0, E0:72 -> 1, E0:6B -> 2, E0:74 -> 3
//    P2: 1D -> 4, 1B -> 5, 1C -> 6, 23 -> 7
//    P3: 43 -> 8, 42 -> 9, 3B -> 10, 4B -> 11
//    P4: 75 -> 12, 73 -> 13, 6B -> 14, 74 -> 15 (keypad, non-extended)
//    29 (space) -> 16
//  Make of a mapped key, code != KEY_PRESSED:
//    KEY_PRESSED <= code and key_valid pulses, both in the cycle after DONE.
//  Make of the same code (typematic repeat): no change and no pulse.
//  Break of a mapped key whose code == KEY_PRESSED: KEY_PRESSED <= IDLE_CODE, no pulse.
//    A break of any other key is ignored.
//  Unmapped make or break: ignored; flags cleared.
//  Latency: key_valid asserts 2 cycles after the synced stop-bit falling edge (STOP->DONE, then DONE->output).
//  Reset asserted mid-frame: the partial frame is dropped, all state returns to reset values,
//    and the first edge after reset is treated as a start bit.
//  Simultaneous reset and DONE: reset wins and no pulse is produced.
//  key_valid and frame_err are never high in the same cycle.
// CONFIGURATION
//  PS2_GLITCH_FILTER_EN defined:
//    The synced PS2_CLK feeds a FILTER_LEN-deep majority-free stable filter.
//    The filtered level changes only after FILTER_LEN identical consecutive samples.
//    Edge detection uses the filtered level. Latency grows by FILTER_LEN cycles.
//  PS2_GLITCH_FILTER_EN undefined: edges are detected directly on the 2-FF synced PS2_CLK and FILTER_LEN is unused.
// TESTING
//  1. Send frames E0,75 -> KEY_PRESSED=0 and one key_valid pulse. Then send E0,F0,75 -> KEY_PRESSED=31, no pulse.
//  2. Send 1D three times (typematic) -> exactly one key_valid pulse and KEY_PRESSED=4.
//     Then send 43 -> KEY_PRESSED=8 with a second pulse. Then send F0,1D -> KEY_PRESSED stays 8.
//  3. Send frame 0x75 with even parity -> frame_err pulse, KEY_PRESSED unchanged.
//     Then send E0,75 -> KEY_PRESSED=0 (flags were not corrupted).
//  4. Send 5 bits of a frame, then hold PS2_CLK high for TIMEOUT_CYCLES+1 -> frame_err pulse and FSM back in IDLE.
//     Then send a full 29 frame -> KEY_PRESSED=16.
//  5. Assert reset for 1 cycle mid-frame after KEY_PRESSED=12 -> KEY_PRESSED=31 and no pulses.
//     Then send 74 (no E0) -> KEY_PRESSED=15.
//  6. With PS2_GLITCH_FILTER_EN, inject 3-cycle low glitches on PS2_CLK during a 1C frame
//     -> KEY_PRESSED=6 and no frame_err. Without the macro, the same stimulus -> frame_err pulse.

Source files
------------

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 receiver and key-code decoder for the game core input stage.
// Optional PS2_GLITCH_FILTER_EN adds a stability filter on the synced PS2_CLK.
module ps2_key_decoder #(
   parameter int          TIMEOUT_CYCLES = 50000,
   parameter int          FILTER_LEN     = 8,
   parameter logic [4:0]  IDLE_CODE      = 5'd31
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       PS2_CLK,
   input  logic       PS2_DAT,
   output logic [4:0] KEY_PRESSED,
   output logic       key_valid,
   output logic       frame_err
);

   // state  | meaning
   // IDLE   | waiting for a start bit
   // DATA   | shifting in 8 data bits, LSB first
   // PARITY | waiting for the odd-parity bit
   // STOP   | waiting for the stop bit
   // DONE   | one cycle: check frame and decode the byte
   typedef enum logic [2:0] {
      S_IDLE, S_DATA, S_PARITY, S_STOP, S_DONE
   } state_t;

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   if (FILTER_LEN < 1) begin : g_filter_len_check
      $error("FILTER_LEN must be at least 1");
   end

   state_t          state, state_nxt;
   logic [1:0]      clk_sync, dat_sync;
   logic            clk_lvl, clk_prev, fall, dat_s;
   logic [TW-1:0]   tmr;
   logic [2:0]      bit_cnt;
   logic [7:0]      shift_reg;
   logic            par_bit, stop_bit;
   logic            ext_flag, brk_flag;
   logic            in_frame, timeout;
   logic            parity_ok;
   logic [5:0]      key_lut;
   logic            key_hit;
   logic [4:0]      key_code;

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         clk_sync <= 2'b11;
         dat_sync <= 2'b11;
      end else begin
         clk_sync <= {clk_sync[0], PS2_CLK};
         dat_sync <= {dat_sync[0], PS2_DAT};
      end
   end

   assign dat_s = dat_sync[1];

`ifdef PS2_GLITCH_FILTER_EN
   localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   logic [FW-1:0] flt_cnt;
   logic          clk_filt;

   // Level follows the synced clock only after FILTER_LEN differing samples in a row.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         clk_filt <= 1'b1;
         flt_cnt  <= '0;
      end else if (clk_sync[1] == clk_filt) begin
         flt_cnt  <= '0;
      end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
         clk_filt <= clk_sync[1];
         flt_cnt  <= '0;
      end else begin
         flt_cnt  <= flt_cnt + 1'b1;
      end
   end

   assign clk_lvl = clk_filt;
`else
   assign clk_lvl = clk_sync[1];
`endif

   always_ff @(posedge CLOCK_50) begin
      if (reset) clk_prev <= 1'b1;
      else       clk_prev <= clk_lvl;
   end

   assign fall      = clk_prev & ~clk_lvl;
   assign in_frame  = (state == S_DATA) || (state == S_PARITY) || (state == S_STOP);
   assign timeout   = in_frame && !fall && (tmr == '0);
   assign parity_ok = ^{par_bit, shift_reg};

   function automatic logic [5:0] lookup(input logic ext, input logic [7:0] b);
      logic [5:0] r;
      r = 6'd0;
      if (ext) begin
         case (b)
            8'h75:   r = {1'b1, 5'd0};
            8'h72:   r = {1'b1, 5'd1};
            8'h6B:   r = {1'b1, 5'd2};
            8'h74:   r = {1'b1, 5'd3};
            default: r = 6'd0;
         endcase
      end else begin
         case (b)
            8'h1D:   r = {1'b1, 5'd4};
            8'h1B:   r = {1'b1, 5'd5};
            8'h1C:   r = {1'b1, 5'd6};
            8'h23:   r = {1'b1, 5'd7};
            8'h43:   r = {1'b1, 5'd8};
            8'h42:   r = {1'b1, 5'd9};
            8'h3B:   r = {1'b1, 5'd10};
            8'h4B:   r = {1'b1, 5'd11};
            8'h75:   r = {1'b1, 5'd12};
            8'h73:   r = {1'b1, 5'd13};
            8'h6B:   r = {1'b1, 5'd14};
            8'h74:   r = {1'b1, 5'd15};
            8'h29:   r = {1'b1, 5'd16};
            default: r = 6'd0;
         endcase
      end
      return r;
   endfunction

   assign key_lut  = lookup(ext_flag, shift_reg);
   assign key_hit  = key_lut[5];
   assign key_code = key_lut[4:0];

   always_ff @(posedge CLOCK_50) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (fall && !dat_s) state_nxt = S_DATA;
         S_DATA:   if (fall && bit_cnt == 3'd7) state_nxt = S_PARITY;
                   else if (timeout)            state_nxt = S_IDLE;
         S_PARITY: if (fall)                    state_nxt = S_STOP;
                   else if (timeout)            state_nxt = S_IDLE;
         S_STOP:   if (fall)                    state_nxt = S_DONE;
                   else if (timeout)            state_nxt = S_IDLE;
         S_DONE:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         tmr         <= '0;
         bit_cnt     <= 3'd0;
         shift_reg   <= 8'd0;
         par_bit     <= 1'b0;
         stop_bit    <= 1'b0;
         ext_flag    <= 1'b0;
         brk_flag    <= 1'b0;
         KEY_PRESSED <= IDLE_CODE;
         key_valid   <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         key_valid <= 1'b0;
         frame_err <= 1'b0;

         if (fall)                          tmr <= TW'(TIMEOUT_CYCLES);
         else if (in_frame && tmr != '0)    tmr <= tmr - 1'b1;

         case (state)
            S_IDLE: begin
               bit_cnt <= 3'd0;
               if (fall && dat_s) frame_err <= 1'b1;
            end
            S_DATA: if (fall) begin
               shift_reg <= {dat_s, shift_reg[7:1]};
               bit_cnt   <= bit_cnt + 3'd1;
            end
            S_PARITY: if (fall) par_bit  <= dat_s;
            S_STOP:   if (fall) stop_bit <= dat_s;
            S_DONE: begin
               if (!parity_ok || !stop_bit) begin
                  frame_err <= 1'b1;
                  ext_flag  <= 1'b0;
                  brk_flag  <= 1'b0;
               end else if (shift_reg == 8'hE0) begin
                  ext_flag <= 1'b1;
               end else if (shift_reg == 8'hF0) begin
                  brk_flag <= 1'b1;
               end else begin
                  ext_flag <= 1'b0;
                  brk_flag <= 1'b0;
                  if (key_hit) begin
                     if (brk_flag) begin
                        if (key_code == KEY_PRESSED) KEY_PRESSED <= IDLE_CODE;
                     end else if (key_code != KEY_PRESSED) begin
                        KEY_PRESSED <= key_code;
                        key_valid   <= 1'b1;
                     end
                  end
               end
            end
            default: ;
         endcase

         if (timeout) begin
            frame_err <= 1'b1;
            ext_flag  <= 1'b0;
            brk_flag  <= 1'b0;
         end
      end
   end

endmodule
